// File: rtl/shift_ex_stage_pkg.sv
// rtl/shift_ex_stage_pkg.sv - R-type shift function codes and stage-wide constants
package shift_ex_stage_pkg;

    localparam int MUX_W = 32;
    localparam int AMT_W = 5;

    localparam logic [5:0] FUNC_SLL  = 6'h00;
    localparam logic [5:0] FUNC_SRL  = 6'h02;
    localparam logic [5:0] FUNC_SRA  = 6'h03;
    localparam logic [5:0] FUNC_SLLV = 6'h04;
    localparam logic [5:0] FUNC_SRLV = 6'h06;
    localparam logic [5:0] FUNC_SRAV = 6'h07;

endpackage

// File: rtl/shift_ex_stage_shift_mux.sv
// rtl/shift_ex_stage_shift_mux.sv - combinational 32-bit barrel shifter (left, logical right, arithmetic right)
module shift_mux
    import shift_ex_stage_pkg::*;
(
    input  logic [MUX_W-1:0] data,
    input  logic [AMT_W-1:0] amt,
    input  logic             right,
    input  logic             arith,
    output logic [MUX_W-1:0] result
);

    logic             fill;
    logic [2*MUX_W-1:0] ext;

    // Right shifts pull in the fill word from above, so one shifter covers SRL and SRA.
    always_comb begin
        fill   = arith & data[MUX_W-1];
        ext    = {{MUX_W{fill}}, data} >> amt;
        result = right ? ext[MUX_W-1:0] : (data << amt);
    end

endmodule

// File: rtl/shift_ex_stage.sv
// rtl/shift_ex_stage.sv - two-stage execute wrapper for R-type shifts with valid/ready and flush
module shift_ex_stage
    import shift_ex_stage_pkg::*;
#(
    parameter int DATA_W            = 32,
    parameter int RD_W              = 5,
    parameter bit ZERO_REG_SUPPRESS = 1'b1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_func,
    input  logic [4:0]        in_sa,
    input  logic [DATA_W-1:0] in_rs,
    input  logic [DATA_W-1:0] in_rt,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_wreg,
    output logic              out_illegal,
    output logic              busy
);

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [4:0]        s1_amt;
    logic              s1_right;
    logic              s1_arith;
    logic              s1_illegal;
    logic [RD_W-1:0]   s1_rd;

    logic              s2_accept;
    logic              s1_adv;
    logic              in_accept;

    logic [4:0]        d_amt;
    logic              d_right;
    logic              d_arith;
    logic              d_illegal;
    logic [DATA_W-1:0] mux_result;
    logic              unused_rs_hi;

    assign unused_rs_hi = ^in_rs[DATA_W-1:5];

    assign s2_accept = !out_valid | out_ready;
    assign s1_adv    = s1_valid & s2_accept;
    assign in_ready  = !flush & (!s1_valid | s1_adv);
    assign in_accept = in_valid & in_ready;
    assign busy      = s1_valid | out_valid;

    always_comb begin
        d_amt     = in_rs[4:0];
        d_right   = 1'b0;
        d_arith   = 1'b0;
        d_illegal = 1'b0;
        case (in_func)
            FUNC_SLL:  d_amt = in_sa;
            FUNC_SRL:  begin d_amt = in_sa; d_right = 1'b1; end
            FUNC_SRA:  begin d_amt = in_sa; d_right = 1'b1; d_arith = 1'b1; end
            FUNC_SLLV: ;
            FUNC_SRLV: d_right = 1'b1;
            FUNC_SRAV: begin d_right = 1'b1; d_arith = 1'b1; end
            default:   d_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s1_amt     <= '0;
            s1_right   <= 1'b0;
            s1_arith   <= 1'b0;
            s1_illegal <= 1'b0;
            s1_rd      <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_accept) begin
            s1_valid   <= 1'b1;
            s1_data    <= in_rt;
            s1_amt     <= d_amt;
            s1_right   <= d_right;
            s1_arith   <= d_arith;
            s1_illegal <= d_illegal;
            s1_rd      <= in_rd;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    shift_mux u_shift_mux (
        .data   (s1_data),
        .amt    (s1_amt),
        .right  (s1_right),
        .arith  (s1_arith),
        .result (mux_result)
    );

    // Flush only drops the valid bit; the result registers keep their last contents.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_rd      <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s1_adv) begin
            out_valid   <= 1'b1;
            out_result  <= s1_illegal ? '0 : mux_result;
            out_rd      <= s1_rd;
            out_illegal <= s1_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_wreg = out_valid & !out_illegal & !(ZERO_REG_SUPPRESS && (out_rd == '0));

endmodule

// File: tb/tb_shift_ex_stage.sv
// tb/tb_shift_ex_stage.sv - randomized and directed self-checking bench for shift_ex_stage
module tb_shift_ex_stage;

    logic        clock = 1'b0;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_func;
    logic [4:0]  in_sa;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wreg;
    logic        out_illegal;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        illegal;
        logic        wreg;
    } res_t;

    res_t exp_q[$];
    res_t obs_q[$];
    logic acc_flag;

    shift_ex_stage dut (
        .clock       (clock),
        .resetn      (resetn),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_func     (in_func),
        .in_sa       (in_sa),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_wreg    (out_wreg),
        .out_illegal (out_illegal),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    // Reference: shifts expressed as multiply/divide by a power of two.
    function automatic res_t model(input logic [5:0] f, input logic [4:0] sa,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [4:0] rd);
        res_t r;
        longint unsigned p;
        longint unsigned x;
        longint unsigned nx;
        int amt;
        r.rd      = rd;
        r.illegal = 1'b0;
        r.result  = 32'h0;
        amt = (f == 6'h00 || f == 6'h02 || f == 6'h03) ? int'(sa) : int'(rs[4:0]);
        p = 1;
        for (int k = 0; k < amt; k++) p = p * 2;
        x  = {32'h0, rt};
        nx = {32'h0, ~rt};
        case (f)
            6'h00, 6'h04: r.result = 32'((x * p) % 64'h1_0000_0000);
            6'h02, 6'h06: r.result = 32'(x / p);
            6'h03, 6'h07: r.result = rt[31] ? ~32'(nx / p) : 32'(x / p);
            default: r.illegal = 1'b1;
        endcase
        r.wreg = !r.illegal && (rd != 5'd0);
        return r;
    endfunction

    task automatic tick();
        #1;
        acc_flag = in_valid && in_ready;
        if (acc_flag) exp_q.push_back(model(in_func, in_sa, in_rs, in_rt, in_rd));
        if (out_valid && out_ready && !flush)
            obs_q.push_back({out_result, out_rd, out_illegal, out_wreg});
        @(negedge clock);
    endtask

    task automatic set_op(input logic [5:0] f, input logic [4:0] sa, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [4:0] rd);
        in_func = f; in_sa = sa; in_rs = rs; in_rt = rt; in_rd = rd;
    endtask

    task automatic rand_op();
        logic [5:0] legal [6];
        logic [5:0] bad [4];
        legal = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
        bad   = '{6'h01, 6'h05, 6'h20, 6'h3F};
        if ($urandom_range(0, 7) == 0) in_func = bad[$urandom_range(0, 3)];
        else                           in_func = legal[$urandom_range(0, 5)];
        in_sa = 5'($urandom); in_rs = $urandom; in_rt = $urandom; in_rd = 5'($urandom);
    endtask

    task automatic test_reset();
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_op(6'h00, 5'd0, 32'h0, 32'h0, 5'd0);
        @(negedge clock); @(negedge clock);
        resetn = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_wreg, out_illegal, busy} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b want=0000", {out_valid, out_wreg, out_illegal, busy});
        end
        checks++;
        if (out_result !== 32'h0 || out_rd !== 5'd0) begin
            failures++; $display("FAIL reset_data got=%h/%0d want=0/0", out_result, out_rd);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        @(negedge clock);
    endtask

    task automatic test_directed();
        logic [31:0] er;
        logic        ew;
        logic        ei;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin set_op(6'h03, 5'd4, 32'h0, 32'h80000000, 5'd5);  er = 32'hF8000000; ew = 1; ei = 0; end
                1: begin set_op(6'h06, 5'd9, 32'h24, 32'hF0000000, 5'd6); er = 32'h0F000000; ew = 1; ei = 0; end
                2: begin set_op(6'h04, 5'd9, 32'h24, 32'hF0000000, 5'd7); er = 32'h00000000; ew = 1; ei = 0; end
                3: begin set_op(6'h00, 5'd31, 32'h0, 32'h1, 5'd8);        er = 32'h80000000; ew = 1; ei = 0; end
                4: begin set_op(6'h02, 5'd0, 32'h7, 32'hDEADBEEF, 5'd0);  er = 32'hDEADBEEF; ew = 0; ei = 0; end
                5: begin set_op(6'h07, 5'd3, 32'h20, 32'h80000001, 5'd9); er = 32'h80000001; ew = 1; ei = 0; end
                default: begin set_op(6'h20, 5'd3, 32'h1, 32'hFFFFFFFF, 5'd3); er = 32'h0; ew = 0; ei = 1; end
            endcase
            in_valid = 1'b1;
            tick();
            checks++;
            if (acc_flag !== 1'b1) begin
                failures++; $display("FAIL dir%0d_accept got=%b want=1", i, acc_flag);
            end
            in_valid = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL dir%0d_early_valid got=%b want=0", i, out_valid);
            end
            tick();
            #1;
            checks++;
            if ({out_valid, out_result, out_wreg, out_illegal} !== {1'b1, er, ew, ei}) begin
                failures++;
                $display("FAIL dir%0d_result got v=%b r=%h w=%b i=%b want v=1 r=%h w=%b i=%b",
                         i, out_valid, out_result, out_wreg, out_illegal, er, ew, ei);
            end
            tick();
            exp_q.delete(); obs_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  f [4];
        logic [4:0]  s [4];
        logic [31:0] a [4];
        logic [31:0] b [4];
        logic [4:0]  d [4];
        logic [38:0] snap;
        int idx;
        int cyc;
        for (int k = 0; k < 4; k++) begin
            f[k] = 6'h03; s[k] = 5'(k + 1); a[k] = $urandom; b[k] = $urandom; d[k] = 5'(k + 1);
        end
        idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            set_op(f[idx], s[idx], a[idx], b[idx], d[idx]);
            in_valid = 1'b1;
            tick();
            if (acc_flag) idx++;
        end
        set_op(f[idx], s[idx], a[idx], b[idx], d[idx]);
        #1;
        checks++;
        if (idx !== 2) begin
            failures++; $display("FAIL b2b_accepted got=%0d want=2", idx);
        end
        checks++;
        if ({in_ready, out_valid} !== 2'b01) begin
            failures++; $display("FAIL b2b_stall_flags got=%b want=01", {in_ready, out_valid});
        end
        snap = {out_valid, out_result, out_rd, out_illegal};
        tick();
        #1;
        checks++;
        if ({out_valid, out_result, out_rd, out_illegal} !== snap) begin
            failures++; $display("FAIL b2b_hold got=%h want=%h", {out_valid, out_result, out_rd, out_illegal}, snap);
        end
        out_ready = 1'b1;
        cyc = 0;
        while ((idx < 4 || obs_q.size() < 4) && cyc < 20) begin
            if (idx < 4) begin
                set_op(f[idx], s[idx], a[idx], b[idx], d[idx]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (acc_flag) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (obs_q.size() !== 4 || exp_q.size() !== 4) begin
            failures++; $display("FAIL b2b_count got=%0d want=4", obs_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    failures++; $display("FAIL b2b_order%0d got=%h want=%h", k, obs_q[k], exp_q[k]);
                end
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_flush();
        logic [31:0] snap_res;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_op(6'h00, 5'd4, 32'h0, 32'h0000_1234, 5'd1);
        tick();
        set_op(6'h02, 5'd4, 32'h0, 32'h0000_5678, 5'd2);
        tick();
        set_op(6'h04, 5'd1, 32'h1, 32'h0000_0001, 5'd3);
        flush = 1'b1;
        #1;
        checks++;
        if ({in_ready, busy, out_valid} !== 3'b011) begin
            failures++; $display("FAIL flush_pre got=%b want=011", {in_ready, busy, out_valid});
        end
        snap_res = out_result;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            failures++; $display("FAIL flush_post got=%b want=00", {out_valid, busy});
        end
        checks++;
        if (out_result !== snap_res) begin
            failures++; $display("FAIL flush_data_kept got=%h want=%h", out_result, snap_res);
        end
        checks++;
        if (exp_q.size() !== 2) begin
            failures++; $display("FAIL flush_accepts got=%0d want=2", exp_q.size());
        end
        out_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (obs_q.size() !== 0) begin
            failures++; $display("FAIL flush_ghost got=%0d want=0", obs_q.size());
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_op(); tick();
        rand_op(); tick();
        in_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_wreg, out_illegal, busy, out_result, out_rd} !== 41'h0) begin
            failures++;
            $display("FAIL rst_mid_outputs got v=%b w=%b i=%b b=%b r=%h d=%0d want all 0",
                     out_valid, out_wreg, out_illegal, busy, out_result, out_rd);
        end
        @(negedge clock);
        resetn = 1'b1;
        out_ready = 1'b1;
        exp_q.delete(); obs_q.delete();
        repeat (5) tick();
        checks++;
        if (obs_q.size() !== 0) begin
            failures++; $display("FAIL rst_mid_ghost got=%0d want=0", obs_q.size());
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random();
        logic        prev_stall;
        logic [38:0] prev_snap;
        int          cyc;
        prev_stall = 1'b0;
        prev_snap  = '0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rand_op();
            #1;
            if (prev_stall) begin
                checks++;
                if ({out_valid, out_result, out_rd, out_illegal} !== prev_snap) begin
                    failures++;
                    $display("FAIL rnd_stall_hold cyc=%0d got=%h want=%h", c,
                             {out_valid, out_result, out_rd, out_illegal}, prev_snap);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_snap  = {out_valid, out_result, out_rd, out_illegal};
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (obs_q.size() < exp_q.size() && cyc < 10) begin
            tick();
            cyc++;
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++; $display("FAIL rnd_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    failures++; $display("FAIL rnd_item%0d got=%h want=%h", k, obs_q[k], exp_q[k]);
                end
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
